tdm_demux_4_1: RTL and testbench
================================

Name: tdm_demux_4_1

Overview:
- Receive end of the 4:1 channel multiplexer path: takes one time-division-multiplexed stream carrying four interleaved lanes (slot 0..3) and rebuilds the four lane values.
- Frame-aligned via a slot-0 sync marker.
- Shadow-buffers a whole frame and presents all four lanes together, so downstream logic sees frame-coherent data.
- Sits directly behind the serial link / mux output, feeding per-lane consumers.

Parameters:
- WIDTH, 1, bits per lane sample (1 = bit-level stream).
- ERR_W, 8, width of saturating sync-error counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  WIDTH  TDM sample for the current slot.
- din_valid  input  1  din carries a sample this cycle.
- frame_sync  input  1  qualified by din_valid; marks the sample as slot 0.
- y0  output  WIDTH  lane 0 value of last complete frame.
- y1  output  WIDTH  lane 1 value of last complete frame.
- y2  output  WIDTH  lane 2 value of last complete frame.
- y3  output  WIDTH  lane 3 value of last complete frame.
- frame_valid  output  1  1-cycle pulse: y0..y3 just updated.
- locked  output  1  level: in LOCKED state.
- sync_err  output  1  1-cycle pulse on a framing violation.
- err_cnt  output  ERR_W  saturating count of sync_err pulses.

Behaviour:
Reset (async, rst_n=0):
- y0..y3=0, frame_valid=0, locked=0, sync_err=0, err_cnt=0.
- Shadow registers =0, slot=0, state=HUNT.
- Reset mid-frame discards the partial frame; y* keep nothing (cleared).

Beat accounting:
- A beat is a cycle with din_valid=1.
- din and frame_sync are ignored when din_valid=0; gaps of any length between beats are allowed.

HUNT (locked=0):
- Beat with frame_sync=1: store din in shadow[0], slot<=1, go LOCKED.
- Beat with frame_sync=0: discarded, no error.

LOCKED (locked=1):
- Beat, frame_sync=0, slot in 1..3: shadow[slot]<=din, slot<=slot+1 (2-bit wrap).
- Beat, slot=3 (completing the frame): y0..y2<=shadow[0..2], y3<=din, all in the same edge. frame_valid=1 in the following cycle (latency 1 clk from last beat), slot<=0.
- Beat, frame_sync=1, slot=0: normal frame start, shadow[0]<=din, slot<=1.
- Beat, frame_sync=1, slot!=0 (early sync): sync_err pulse, partial frame dropped (y* unchanged, no frame_valid), beat taken as new slot 0, slot<=1, stay LOCKED.
- Beat, frame_sync=0, slot=0 (missing sync): sync_err pulse, beat discarded, go HUNT.

Outputs and counter:
- All outputs are registered.
- y* hold their value between frames.
- err_cnt increments on each sync_err and saturates at 2^ERR_W-1, with no wrap.
- Back-to-back frames at full rate (4 beats, then sync beat next cycle) are sustained with no bubble. frame_valid and the next slot-0 capture can coincide.

Decomposition:
- Shared package tdm_pkg: SLOTS=4, SLOT_W=2, state encoding HUNT=1'b0 / LOCKED=1'b1. This package is shared with the transmit-side TDM mux.
- One sub-module is natural: tdm_frame_ctrl (state machine, slot counter, sync_err, err_cnt).
- Lane shadow and output registers stay in the top.

Test Plan:
- Reset, then beats sync=1,d=1; 0,d=0; 0,d=1; 0,d=1 (WIDTH=1) -> one cycle after 4th beat: y0=1,y1=0,y2=1,y3=1, frame_valid=1 for exactly 1 clk, locked=1.
- Beats before first sync (3 beats sync=0), then a valid frame -> no sync_err, frame_valid only after the synced frame, locked rises the cycle after the sync beat.
- Mid-frame early sync: sync beat, 1 beat, then sync beat with d=1 -> sync_err=1 for 1 clk, err_cnt=1, y* unchanged, next 3 beats complete frame with y0=1.
- Missing sync: full frame, then beat with sync=0 at slot 0 -> sync_err pulse, locked=0 next cycle, beat discarded, err_cnt increments.
- Stream with random din_valid gaps plus continuous back-to-back frames -> every frame output matches the transmitted lanes, with no lost or extra frame_valid. Force 300 errors with ERR_W=8 -> err_cnt holds at 255.
- Assert rst_n=0 asynchronously after 2 beats of a frame -> all outputs 0 immediately. After release, a frame needs a new sync and the old partial data never appears.

Source files
------------

// File: rtl/tdm_pkg.sv
// tdm_pkg
//   Shared definitions for the TDM mux/demux pair: frame geometry (slots per
//   frame, slot index width), the receive framer state encoding and a slot
//   increment helper.
package tdm_pkg;

    localparam int SLOTS  = 4;
    localparam int SLOT_W = 2;

    typedef logic [SLOT_W-1:0] slot_t;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_t;

    // Slot index advance; wraps naturally at SLOT_W bits.
    function automatic slot_t slot_inc(input slot_t s);
        return s + slot_t'(1);
    endfunction

endpackage

// File: rtl/tdm_frame_ctrl.sv
// tdm_frame_ctrl
//   Frame alignment control for the TDM receiver: HUNT/LOCKED state machine,
//   slot counter, framing-error pulse and saturating error counter.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   din_valid      beat qualifier
//   frame_sync     slot-0 marker (qualified by din_valid)
//   cap_en         comb: store din into shadow[cap_slot] this beat
//   cap_slot       comb: shadow index to write
//   frame_done     comb: this beat completes a frame (load outputs)
//   locked         registered: state == LOCKED
//   sync_err       registered 1-cycle framing violation pulse
//   err_cnt        registered saturating count of sync_err pulses
module tdm_frame_ctrl
    import tdm_pkg::*;
#(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic             cap_en,
    output slot_t            cap_slot,
    output logic             frame_done,
    output logic             locked,
    output logic             sync_err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [ERR_W-1:0] ERR_MAX  = '1;
    localparam slot_t            LAST_SLOT = slot_t'(SLOTS - 1);

    tdm_state_t state, state_nxt;
    slot_t      slot, slot_nxt;
    logic       err_hit;

    always_comb begin
        state_nxt  = state;
        slot_nxt   = slot;
        cap_en     = 1'b0;
        cap_slot   = slot;
        frame_done = 1'b0;
        err_hit    = 1'b0;
        if (din_valid) begin
            case (state)
                HUNT: begin
                    // Non-sync beats are dropped silently while hunting.
                    if (frame_sync) begin
                        cap_en    = 1'b1;
                        cap_slot  = '0;
                        slot_nxt  = slot_t'(1);
                        state_nxt = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_sync) begin
                        // Sync always restarts the frame; mid-frame it also
                        // flags an error and the partial frame is abandoned.
                        err_hit  = (slot != '0);
                        cap_en   = 1'b1;
                        cap_slot = '0;
                        slot_nxt = slot_t'(1);
                    end else if (slot == '0) begin
                        // Expected a sync marker: lose lock, drop the beat.
                        err_hit   = 1'b1;
                        state_nxt = HUNT;
                    end else if (slot == LAST_SLOT) begin
                        // Last lane goes straight to the output, no shadow.
                        frame_done = 1'b1;
                        slot_nxt   = '0;
                    end else begin
                        cap_en   = 1'b1;
                        slot_nxt = slot_inc(slot);
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= HUNT;
            slot     <= '0;
            sync_err <= 1'b0;
            err_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            slot     <= slot_nxt;
            sync_err <= err_hit;
            if (err_hit && err_cnt != ERR_MAX)
                err_cnt <= err_cnt + 1'b1;
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: rtl/tdm_demux_4_1.sv
// tdm_demux_4_1
//   Receive side of the 4:1 TDM link. Aligns to the slot-0 sync marker,
//   shadow-buffers lanes 0..2 of the frame in progress and updates all four
//   lane outputs together when the frame's last beat arrives.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   din            TDM sample for the current slot (WIDTH bits)
//   din_valid      din carries a sample this cycle
//   frame_sync     marks the sample as slot 0 (qualified by din_valid)
//   y0..y3         lane values of the last complete frame
//   frame_valid    1-cycle pulse: y0..y3 just updated
//   locked         framer is in LOCKED
//   sync_err       1-cycle framing violation pulse
//   err_cnt        saturating sync_err count
module tdm_demux_4_1
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic             frame_valid,
    output logic             locked,
    output logic             sync_err,
    output logic [ERR_W-1:0] err_cnt
);

    logic  cap_en;
    slot_t cap_slot;
    logic  frame_done;

    // Only lanes 0..2 need shadowing; the last lane is taken directly from din.
    logic [SLOTS-2:0][WIDTH-1:0] shadow;
    logic [SLOTS-1:0][WIDTH-1:0] lane;

    tdm_frame_ctrl #(
        .ERR_W (ERR_W)
    ) u_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .cap_en     (cap_en),
        .cap_slot   (cap_slot),
        .frame_done (frame_done),
        .locked     (locked),
        .sync_err   (sync_err),
        .err_cnt    (err_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (cap_en) begin
            for (int i = 0; i < SLOTS - 1; i++)
                if (cap_slot == slot_t'(i))
                    shadow[i] <= din;
        end
    end

    // The whole frame is published on one edge so consumers never see a mix
    // of two frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane        <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= frame_done;
            if (frame_done)
                lane <= {din, shadow};
        end
    end

    assign y0 = lane[0];
    assign y1 = lane[1];
    assign y2 = lane[2];
    assign y3 = lane[3];

endmodule

// File: tb/tb_tdm_demux_4_1.sv
module tb_tdm_demux_4_1;

    localparam int WIDTH = 1;
    localparam int ERR_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             din_valid = 1'b0;
    logic             frame_sync = 1'b0;
    logic [WIDTH-1:0] y0, y1, y2, y3;
    logic             frame_valid, locked, sync_err;
    logic [ERR_W-1:0] err_cnt;

    int n_chk = 0;
    int n_err = 0;

    tdm_demux_4_1 #(.WIDTH(WIDTH), .ERR_W(ERR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .y0          (y0),
        .y1          (y1),
        .y2          (y2),
        .y3          (y3),
        .frame_valid (frame_valid),
        .locked      (locked),
        .sync_err    (sync_err),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Present one beat at a negedge; returns at the next negedge with the
    // result of the intervening posedge visible on the outputs.
    task automatic beat(input logic s, input logic d);
        din_valid  = 1'b1;
        frame_sync = s;
        din        = d;
        @(negedge clk);
        din_valid  = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [3:0] ys();
        return {y3, y2, y1, y0};
    endfunction

    logic [3:0] l;
    int         e;

    initial begin
        idle(3);
        chk("rst_y", ys(), 4'h0);
        chk("rst_fv", frame_valid, 0);
        chk("rst_lock", locked, 0);
        chk("rst_serr", sync_err, 0);
        chk("rst_ecnt", err_cnt, 0);
        rst_n = 1'b1;

        // Basic frame: lanes 1,0,1,1
        beat(1, 1); chk("t1_lock", locked, 1);
        beat(0, 0); chk("t1_fv0", frame_valid, 0);
        beat(0, 1);
        beat(0, 1);
        chk("t1_y", ys(), 4'b1101);
        chk("t1_fv", frame_valid, 1);
        idle(1);
        chk("t1_fv_pulse", frame_valid, 0);
        chk("t1_hold", ys(), 4'b1101);

        // Beats before first sync are ignored quietly
        rst_n = 1'b0; idle(1); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            beat(0, 1);
            chk("t2_lock", locked, 0);
            chk("t2_serr", sync_err, 0);
            chk("t2_fv", frame_valid, 0);
        end
        beat(1, 0); chk("t2_lock_up", locked, 1);
        beat(0, 1); beat(0, 1);
        chk("t2_fv_early", frame_valid, 0);
        beat(0, 0);
        chk("t2_y", ys(), 4'b0110);
        chk("t2_fv", frame_valid, 1);

        // Early sync mid-frame
        beat(1, 0); beat(0, 1);
        beat(1, 1);
        chk("t3_serr", sync_err, 1);
        chk("t3_ecnt", err_cnt, 1);
        chk("t3_y", ys(), 4'b0110);
        chk("t3_fv", frame_valid, 0);
        chk("t3_lock", locked, 1);
        idle(1);
        chk("t3_serr_pulse", sync_err, 0);
        beat(0, 0); beat(0, 1); beat(0, 0);
        chk("t3_y2", ys(), 4'b0101);
        chk("t3_fv2", frame_valid, 1);

        // Missing sync
        beat(1, 0); beat(0, 0); beat(0, 0); beat(0, 1);
        chk("t4_y", ys(), 4'b1000);
        beat(0, 1);
        chk("t4_serr", sync_err, 1);
        chk("t4_lock", locked, 0);
        chk("t4_ecnt", err_cnt, 2);
        chk("t4_y_hold", ys(), 4'b1000);
        chk("t4_fv", frame_valid, 0);

        // Random lanes, gapped frames then back-to-back frames
        for (int f = 0; f < 24; f++) begin
            l = 4'($urandom);
            for (int k = 0; k < 4; k++) begin
                if (f < 12 && $urandom_range(0, 1) == 1) begin
                    idle($urandom_range(1, 3));
                    chk("t5_fv_gap", frame_valid, 0);
                end
                beat(k == 0, l[k]);
                chk("t5_fv", frame_valid, k == 3);
                if (k == 0) chk("t5_serr", sync_err, 0);
            end
            chk("t5_y", ys(), l);
        end
        chk("t5_ecnt", err_cnt, 2);

        // Error counter saturation via repeated early syncs
        e = 2;
        beat(1, 0);
        chk("t6_serr0", sync_err, 0);
        for (int i = 0; i < 300; i++) begin
            beat(1, 0);
            e = (e < 255) ? e + 1 : 255;
            chk("t6_serr", sync_err, 1);
            chk("t6_ecnt", err_cnt, e);
        end
        chk("t6_sat", err_cnt, 255);

        // Async reset mid-frame
        beat(1, 1); beat(0, 1); beat(0, 1); beat(0, 1);
        chk("t7_y_pre", ys(), 4'b1111);
        beat(1, 1); beat(0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_y_rst", ys(), 4'h0);
        chk("t7_lock_rst", locked, 0);
        chk("t7_ecnt_rst", err_cnt, 0);
        chk("t7_fv_rst", frame_valid, 0);
        chk("t7_serr_rst", sync_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        beat(0, 1); beat(0, 1);
        chk("t7_lock_nosync", locked, 0);
        chk("t7_fv_nosync", frame_valid, 0);
        chk("t7_y_nosync", ys(), 4'h0);
        beat(1, 0); beat(0, 0); beat(0, 1);
        chk("t7_y_mid", ys(), 4'h0);
        beat(0, 0);
        chk("t7_y", ys(), 4'b0100);
        chk("t7_fv", frame_valid, 1);
        chk("t7_ecnt", err_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
